// File: rtl/sb_xform_loopback_if.sv
// Stream bundle for sb_xform_loopback: one input beat stream and one output
// beat stream, each with a valid/ready handshake. Signal names match the
// block's port list so the interface reads the same as the flat port map.
interface sb_xform_loopback_if #(
    parameter int DW = 256
);
    logic [DW-1:0] in_data;
    logic [31:0]   in_dest;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [31:0]   out_dest;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;

    // Producer / consumer side (testbench or surrounding logic).
    modport master (
        output in_data, in_dest, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_dest, out_last, out_valid
    );

    // Transform buffer side.
    modport slave (
        input  in_data, in_dest, in_last, in_valid, out_ready,
        output in_ready, out_data, out_dest, out_last, out_valid
    );
endinterface

// File: rtl/sb_xform_loopback.sv
// Transforming loopback buffer. Each accepted beat is transformed according
// to the mode sampled at accept time, then held in a small FIFO until the
// downstream side pops it. dest/last ride along untouched. Also keeps a
// saturating packet counter and a sticky flag for an all-ones input beat.
module sb_xform_loopback #(
    parameter int         DW    = 256,
    parameter int         DEPTH = 4,
    parameter logic [7:0] INC   = 8'd1
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic [1:0]                 mode,
    sb_xform_loopback_if.slave         bus,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [31:0]                pkt_count,
    output logic                       done
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int NB = DW / 8;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // Byte-wise transform applied once, on the way into the buffer, so a
    // later mode change cannot affect beats that are already stored.
    function automatic logic [DW-1:0] xform(input logic [DW-1:0] d, input logic [1:0] m);
        logic [DW-1:0] r;
        r = d;
        case (m)
            2'd0: r = d;
            2'd1: for (int i = 0; i < NB; i++) r[i*8 +: 8] = d[i*8 +: 8] + INC;
            2'd2: r = ~d;
            2'd3: for (int i = 0; i < NB; i++) r[i*8 +: 8] = d[(NB-1-i)*8 +: 8];
            default: r = d;
        endcase
        return r;
    endfunction

    logic [DW-1:0] data_mem_r [DEPTH];
    logic [31:0]   dest_mem_r [DEPTH];
    logic          last_mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [31:0]   pkt_count_r;
    logic          done_r;
    logic          push_s;
    logic          pop_s;

    // in_ready/out_valid are registered copies of the occupancy test, so
    // nothing on the input side reaches the output side combinationally.
    assign push_s = bus.in_valid && in_ready_r;
    assign pop_s  = out_valid_r && bus.out_ready;

    // Next occupancy: simultaneous push and pop leaves the level unchanged.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_ONE;
            2'b01:   level_nxt_s = level_r - LVL_ONE;
            default: level_nxt_s = level_r;
        endcase
    end

    // Beat storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= xform(bus.in_data, mode);
            dest_mem_r[wr_ptr_r] <= bus.in_dest;
            last_mem_r[wr_ptr_r] <= bus.in_last;
        end
    end

    // Pointers, occupancy, handshake flags and status counters.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            level_r     <= {LW{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            pkt_count_r <= 32'd0;
            done_r      <= 1'b0;
        end else begin
            // Power-of-two depth: pointers wrap naturally at DEPTH-1.
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            level_r     <= level_nxt_s;
            in_ready_r  <= (level_nxt_s < DEPTH_L);
            out_valid_r <= (level_nxt_s != {LW{1'b0}});
            if (push_s && bus.in_last && (pkt_count_r != 32'hFFFF_FFFF)) begin
                pkt_count_r <= pkt_count_r + 32'd1;
            end
            if (push_s && (&bus.in_data)) begin
                done_r <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = data_mem_r[rd_ptr_r];
    assign bus.out_dest  = dest_mem_r[rd_ptr_r];
    assign bus.out_last  = last_mem_r[rd_ptr_r];
    assign level         = level_r;
    assign pkt_count     = pkt_count_r;
    assign done          = done_r;
endmodule

// File: tb/tb_sb_xform_loopback.sv
// Directed self-checking bench for sb_xform_loopback (DW=256, DEPTH=4, INC=1).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_sb_xform_loopback;
    localparam int DW    = 256;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        nreset;
    logic [1:0]  mode;
    logic [2:0]  level;
    logic [31:0] pkt_count;
    logic        done;
    int          checks = 0;
    int          errors = 0;

    sb_xform_loopback_if #(.DW(DW)) bus ();

    sb_xform_loopback #(.DW(DW), .DEPTH(DEPTH), .INC(8'd1)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .mode      (mode),
        .bus       (bus),
        .level     (level),
        .pkt_count (pkt_count),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; mode = 2'd0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_dest = 32'd0;
        bus.in_last = 1'b0; bus.out_ready = 1'b0;
        tick(); tick();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
        checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL rst_pkt_count got %0d exp 0", pkt_count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        nreset = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b exp 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_add_inc();
        logic [DW-1:0] exp_d;
        exp_d = {32{8'h11}};
        mode = 2'd1; bus.out_ready = 1'b1;
        bus.in_data = {32{8'h10}}; bus.in_dest = 32'd5; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL add_data got %h exp %h", bus.out_data, exp_d); end
        checks++; if (bus.out_dest !== 32'd5) begin errors++; $display("FAIL add_dest got %0d exp 5", bus.out_dest); end
        checks++; if (bus.out_last !== 1'b1) begin errors++; $display("FAIL add_last got %b exp 1", bus.out_last); end
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL add_pkt got %0d exp 1", pkt_count); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL add_level got %0d exp 1", level); end
        tick();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL add_drain_level got %0d exp 0", level); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain_valid got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_wrap_done();
        logic [DW-1:0] exp_d;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pre got %b exp 0", done); end
        mode = 2'd1; bus.in_data = {32{8'hFF}}; bus.in_dest = 32'd9; bus.in_last = 1'b0; bus.in_valid = 1'b1;
        tick();
        bus.in_data = {32{8'h33}};
        exp_d = {DW{1'b0}};
        checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL wrap_data got %h exp %h", bus.out_data, exp_d); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_set got %b exp 1", done); end
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL wrap_pkt got %0d exp 1", pkt_count); end
        tick();
        bus.in_valid = 1'b0;
        exp_d = {32{8'h34}};
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL wrap_pushpop_level got %0d exp 1", level); end
        checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL wrap_next_data got %h exp %h", bus.out_data, exp_d); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_sticky got %b exp 1", done); end
        tick();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL wrap_drain_level got %0d exp 0", level); end
    endtask

    task automatic test_full();
        logic [7:0]    b;
        logic [DW-1:0] exp_d;
        bus.out_ready = 1'b0; mode = 2'd2; bus.in_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            b = 8'hA0 + 8'(k);
            bus.in_data = {32{b}}; bus.in_dest = 32'(k); bus.in_valid = 1'b1;
            tick();
            if (k >= 3) begin
                checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level k=%0d got %0d exp 4", k, level); end
                checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready k=%0d got %b exp 0", k, bus.in_ready); end
            end
        end
        exp_d = ~{32{8'hA0}};
        checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL full_hold_data got %h exp %h", bus.out_data, exp_d); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_pop_level got %0d exp 3", level); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_in_ready got %b exp 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            b = 8'hA0 + 8'(k);
            exp_d = ~{32{b}};
            checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL full_order_data k=%0d got %h exp %h", k, bus.out_data, exp_d); end
            checks++; if (bus.out_dest !== 32'(k)) begin errors++; $display("FAIL full_order_dest got %0d exp %0d", bus.out_dest, k); end
            tick();
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_drain_valid got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_reverse();
        logic [DW-1:0] din;
        logic [DW-1:0] exp_d;
        for (int i = 0; i < 32; i++) begin
            din[i*8 +: 8]   = 8'(i);
            exp_d[i*8 +: 8] = 8'(31 - i);
        end
        bus.out_ready = 1'b0; mode = 2'd3;
        bus.in_data = din; bus.in_dest = 32'd7; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0; mode = 2'd0;
        tick(); tick();
        checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL rev_data got %h exp %h", bus.out_data, exp_d); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rev_valid got %b exp 1", bus.out_valid); end
        checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL rev_pkt got %0d exp 2", pkt_count); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rev_drain_level got %0d exp 0", level); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]    b;
        logic [DW-1:0] exp_d;
        mode = 2'd0; bus.out_ready = 1'b1; bus.in_last = 1'b0;
        for (int k = 0; k < 20; k++) begin
            b = 8'(k);
            bus.in_data = {32{b}}; bus.in_dest = 32'(k); bus.in_valid = 1'b1;
            tick();
            exp_d = {32{b}};
            checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_level k=%0d got %0d exp 1", k, level); end
            checks++; if (bus.out_data !== exp_d || bus.out_dest !== 32'(k)) begin
                errors++; $display("FAIL b2b_beat k=%0d got dest %0d exp %0d", k, bus.out_dest, k);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_drain_level got %0d exp 0", level); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        bus.out_ready = 1'b0; mode = 2'd0; bus.in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b = 8'hC0 + 8'(k);
            bus.in_data = {32{b}}; bus.in_dest = 32'(k); bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_pre_level got %0d exp 3", level); end
        checks++; if (pkt_count !== 32'd5) begin errors++; $display("FAIL mid_pre_pkt got %0d exp 5", pkt_count); end
        #2 nreset = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", bus.out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_rst_level got %0d exp 0", level); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b exp 0", bus.in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b exp 0", done); end
        tick();
        nreset = 1'b1; bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b0 || level !== 3'd0) begin
                errors++; $display("FAIL mid_stale k=%0d got valid %b level %0d exp 0 0", k, bus.out_valid, level);
            end
        end
        checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL mid_pkt got %0d exp 0", pkt_count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", bus.in_ready); end
    endtask

    initial begin
        test_reset();
        test_add_inc();
        test_wrap_done();
        test_full();
        test_reverse();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sb_xform_loopback.md
SB_XFORM_LOOPBACK -- requirements
Module: sb_xform_loopback

Interface
REQ-001 Parameter DW, default 256, data width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter DEPTH, default 4, buffer entries; SHALL be a power of 2 and at least 2.
REQ-003 Parameter INC, default 8'd1, per-byte addend used in mode 1.
REQ-004 Ports (name direction width meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- nreset  in  1  asynchronous, active-low reset.
- mode  in  2  transform select: 0 pass, 1 add INC per byte, 2 bitwise invert, 3 byte-reverse.
- in_data  in  DW  input beat data.
- in_dest  in  32  input destination.
- in_last  in  1  input end-of-packet.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when high with in_valid.
- out_data  out  DW  transformed data.
- out_dest  out  32  destination, passed through unchanged.
- out_last  out  1  end-of-packet, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- level  out  $clog2(DEPTH+1)  current buffer occupancy.
- pkt_count  out  32  accepted packets (beats with in_last).
- done  out  1  sticky flag: all-ones beat accepted.

Function
REQ-005 Input accept (push) SHALL occur exactly when in_valid && in_ready at a rising clk edge.
REQ-006 in_ready SHALL equal (level < DEPTH); a pop in the same cycle SHALL NOT raise in_ready when full.
REQ-007 Output pop SHALL occur exactly when out_valid && out_ready; out_valid SHALL equal (level != 0).
REQ-008 The transform SHALL be applied at push time using mode sampled in that cycle; mode changes SHALL NOT alter buffered beats.
REQ-009 Mode 1: each byte i of out_data SHALL be (in_data byte i + INC) mod 256, with no carry between bytes.
REQ-010 Mode 2: out_data SHALL be the bitwise NOT of in_data.
REQ-011 Mode 3: out_data byte i SHALL be in_data byte (DW/8-1-i).
REQ-012 Buffering SHALL be FIFO-ordered; dest and last SHALL travel with their data beat.
REQ-013 Latency: a beat pushed into an empty buffer SHALL appear on out_* with out_valid high in the next cycle; there SHALL be no combinational path from in_* to out_*.
REQ-014 out_data, out_dest and out_last SHALL hold stable while out_valid && !out_ready.
REQ-015 level SHALL increment on push-only, decrement on pop-only, and stay unchanged on simultaneous push and pop.
REQ-016 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-017 Full with one pop: the next cycle level SHALL be DEPTH-1 and in_ready SHALL be high.
REQ-018 Empty with one push: the next cycle level SHALL be 1; a pop SHALL never occur while empty.
REQ-019 pkt_count SHALL increment by 1 on each push with in_last=1 and SHALL saturate at 32'hFFFFFFFF.
REQ-020 done SHALL be set on any push whose pre-transform in_data is all ones, and SHALL remain set until reset.

Reset
REQ-021 While nreset=0 (asserted asynchronously): level=0, out_valid=0, in_ready=0, pkt_count=0, done=0, pointers=0.
REQ-022 After nreset deasserts, in_ready SHALL rise at the first rising clk edge.
REQ-023 Reset mid-operation SHALL discard all buffered beats; no beat buffered before reset SHALL appear at the output afterwards.
REQ-024 Buffer storage contents need no reset; out_data, out_dest and out_last are don't-care while out_valid=0.

Verification
REQ-025 DW=256, mode=1, push data of all bytes 8'h10, dest=5, last=1, out_ready=1 -> next cycle out_data all bytes 8'h11, out_dest=5, out_last=1, pkt_count=1.
REQ-026 mode=1, all bytes 8'hFF -> out bytes 8'h00 (no inter-byte carry) and done=1 sticky.
REQ-027 DEPTH=4, out_ready=0, push 5 beats -> in_ready low after 4 pushes, level=4; the 5th beat stalls. Raise out_ready for 1 cycle -> level=3, in_ready=1, and the first beat is popped.
REQ-028 mode=3, in byte i = i (0..31) -> out byte i = 31-i. Change mode to 0 while the beat is buffered -> output unchanged.
REQ-029 Continuous push and pop with out_ready=1 for 20 beats -> level constant at 1, pointer wrap exercised, order preserved.
REQ-030 Assert nreset with 3 beats buffered -> out_valid=0 and level=0 immediately; after release, no stale beat is emitted and pkt_count=0.
